regfile_sb: RTL and testbench

- Parametrised successor to the CPU's 3-bit-address, two-read-port register file; adds reset, N read ports and a per-register pending-write scoreboard.
- Sits between the ID stage (reads, issue of writes) and the WB stage (write-back).
- Lets the pipeline detect RAW hazards and stall instead of reading stale operands.
- Register 0 stays the BA register.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_pend_counter.sv | 40 ++++
 rtl/regfile_sb.sv | 103 ++++++++++
 tb/tb_regfile_sb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants, types and helpers for the scoreboarded register file.
package rf_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned ADDR_W_DEF   = 3;
    localparam logic [15:0] BA_RESET_DEF = 16'h0400;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_word_t;

    // Counter width able to hold 0..pend_max inclusive.
    function automatic int unsigned pend_w_f(input int unsigned pend_max);
        return $clog2(pend_max + 1);
    endfunction

endpackage

// File: rtl/rf_pend_counter.sv
// Saturating up/down counter tracking in-flight writes for one register.
module rf_pend_counter #(
    parameter int unsigned PEND_MAX = 3,
    parameter int unsigned PEND_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] cnt_o,
    output logic              sat_o,
    output logic              zero_o
);

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;

    assign sat_o  = (cnt_q == PEND_W'(PEND_MAX));
    assign zero_o = (cnt_q == '0);
    assign cnt_o  = cnt_q;

    // Simultaneous inc and dec cancel; both ends clamp rather than wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !sat_o) begin
            cnt_d = cnt_q + PEND_W'(1);
        end else if (dec_i && !inc_i && !zero_o) begin
            cnt_d = cnt_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register pending-write scoreboard.
// Optional same-cycle write-back forwarding to reads: define RF_BYPASS_EN.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       NUM_RD   = 2,
    parameter int unsigned       PEND_MAX = 3,
    parameter logic [DATA_W-1:0] BA_RESET = DATA_W'(BA_RESET_DEF)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_ready,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     wb_err
);

    localparam int unsigned NREGS  = 2 ** ADDR_W;
    localparam int unsigned PEND_W = pend_w_f(PEND_MAX);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [PEND_W-1:0] cnt    [NREGS];
    logic [NREGS-1:0]  sat;
    logic [NREGS-1:0]  zero;
    logic [NREGS-1:0]  inc;
    logic [NREGS-1:0]  dec;
    logic              issue_acc;
    logic              wb_err_q;
    logic              wb_err_d;

    // A write-back to the same register frees a slot even when saturated.
    assign issue_ready = !sat[issue_addr] || (wb_valid && (wb_addr == issue_addr));
    assign issue_acc   = issue_valid && issue_ready;

    for (genvar r = 0; r < NREGS; r++) begin : g_pend
        assign inc[r] = issue_acc && (issue_addr == ADDR_W'(r));
        assign dec[r] = wb_valid && (wb_addr == ADDR_W'(r));

        rf_pend_counter #(
            .PEND_MAX (PEND_MAX),
            .PEND_W   (PEND_W)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc_i  (inc[r]),
            .dec_i  (dec[r]),
            .cnt_o  (cnt[r]),
            .sat_o  (sat[r]),
            .zero_o (zero[r])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= (r == 0) ? BA_RESET : '0;
            end
        end else if (wb_valid) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Orphan write-back: nothing pending and no same-cycle issue to cover it.
    always_comb begin
        wb_err_d = wb_err_q;
        if (wb_valid && zero[wb_addr] && !(issue_acc && (issue_addr == wb_addr))) begin
            wb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_err_q <= 1'b0;
        end else begin
            wb_err_q <= wb_err_d;
        end
    end

    assign wb_err = wb_err_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[i*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
        logic wb_hit;
        assign wb_hit = wb_valid && (wb_addr == addr);
        assign rd_data[i*DATA_W +: DATA_W] = wb_hit ? wb_data : regs_q[addr];
        assign rd_busy[i] = (cnt[addr] != '0) && !(wb_hit && (cnt[addr] == PEND_W'(1)));
`else
        assign rd_data[i*DATA_W +: DATA_W] = regs_q[addr];
        assign rd_busy[i] = (cnt[addr] != '0);
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: driver queues expectations, negedge monitor checks them.
module tb_regfile_sb;
    import rf_pkg::*;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int SEL_RD0   = 0;
    localparam int SEL_RD1   = 1;
    localparam int SEL_BUSY  = 2;
    localparam int SEL_READY = 3;
    localparam int SEL_ERR   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        issue_valid;
    reg_addr_t   issue_addr;
    logic        issue_ready;
    logic        wb_valid;
    reg_addr_t   wb_addr;
    reg_word_t   wb_data;
    logic        wb_err;

    int n_cmp = 0;
    int n_bad = 0;

    string name_q[$];
    int    sel_q[$];
    int    exp_q[$];

    regfile_sb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    function automatic int get_act(input int sel);
        case (sel)
            SEL_RD0:   return int'(rd_data[15:0]);
            SEL_RD1:   return int'(rd_data[31:16]);
            SEL_BUSY:  return int'(rd_busy);
            SEL_READY: return int'(issue_ready);
            default:   return int'(wb_err);
        endcase
    endfunction

    // Monitor: outputs are presented mid-cycle, after the driver has settled inputs.
    always @(negedge clk) begin
        while (sel_q.size() > 0) begin
            string nm;
            int    sl;
            int    ex;
            int    ac;
            nm = name_q.pop_front();
            sl = sel_q.pop_front();
            ex = exp_q.pop_front();
            ac = get_act(sl);
            n_cmp++;
            if (ac !== ex) begin
                n_bad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", nm, ac, ex);
            end
        end
    end

    task automatic expect_v(input string nm, input int sel, input int ex);
        name_q.push_back(nm);
        sel_q.push_back(sel);
        exp_q.push_back(ex);
    endtask

    // Apply one cycle's inputs just after the rising edge.
    task automatic cyc(input bit rst, input bit iv, input int ia,
                       input bit wv, input int wa, input int wd,
                       input int ra0, input int ra1);
        @(posedge clk);
        #1;
        rst_n       = rst;
        issue_valid = iv;
        issue_addr  = reg_addr_t'(ia);
        wb_valid    = wv;
        wb_addr     = reg_addr_t'(wa);
        wb_data     = reg_word_t'(wd);
        rd_addr     = {reg_addr_t'(ra1), reg_addr_t'(ra0)};
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; issue_valid = 1'b0; issue_addr = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk);

        // Reset state across all addresses
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        expect_v("rst_rd_r0", SEL_RD0, 'h0400);
        expect_v("rst_rd_r1", SEL_RD1, 'h0000);
        expect_v("rst_busy", SEL_BUSY, 0);
        expect_v("rst_ready", SEL_READY, 1);
        expect_v("rst_err", SEL_ERR, 0);
        for (int a = 2; a < 8; a += 2) begin
            cyc(1, 0, 0, 0, 0, 0, a, a + 1);
            expect_v("rst_rd_even", SEL_RD0, 0);
            expect_v("rst_rd_odd", SEL_RD1, 0);
            expect_v("rst_busy_n", SEL_BUSY, 0);
        end

        // Write/read on r5 (issued first so the write-back is legitimate)
        cyc(1, 1, 5, 0, 0, 0, 5, 0);
        expect_v("wr_issue_ready", SEL_READY, 1);
        cyc(1, 0, 0, 1, 5, 'hBEEF, 5, 0);
        expect_v("wr_same_cycle", SEL_RD0, BYP ? 'hBEEF : 'h0000);
        expect_v("wr_busy_same", SEL_BUSY, BYP ? 0 : 1);
        cyc(1, 0, 0, 0, 0, 0, 5, 0);
        expect_v("wr_next_cycle", SEL_RD0, 'hBEEF);
        expect_v("wr_busy_next", SEL_BUSY, 0);
        expect_v("wr_err", SEL_ERR, 0);

        // Saturation on r3
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 3, 0, 0, 0, 3, 5);
            expect_v("sat_issue_ready", SEL_READY, 1);
        end
        cyc(1, 1, 3, 0, 0, 0, 3, 5);
        expect_v("sat_fourth_ready", SEL_READY, 0);
        expect_v("sat_busy", SEL_BUSY, 1);
        cyc(1, 1, 3, 1, 3, 'h00AA, 3, 5);
        expect_v("sat_wb_issue_ready", SEL_READY, 1);
        cyc(1, 0, 3, 0, 0, 0, 3, 5);
        expect_v("sat_still_full", SEL_READY, 0);
        expect_v("sat_data", SEL_RD0, 'h00AA);

        // Drain r3 with three write-backs
        cyc(1, 0, 0, 1, 3, 'h0011, 3, 5);
        expect_v("drain1_busy", SEL_BUSY, 1);
        expect_v("drain1_rd1", SEL_RD1, 'hBEEF);
        cyc(1, 0, 0, 1, 3, 'h0022, 3, 5);
        expect_v("drain2_busy", SEL_BUSY, 1);
        cyc(1, 0, 0, 1, 3, 'h0033, 3, 5);
        expect_v("drain3_busy", SEL_BUSY, BYP ? 0 : 1);
        expect_v("drain3_rd", SEL_RD0, BYP ? 'h0033 : 'h0022);
        cyc(1, 0, 3, 0, 0, 0, 3, 5);
        expect_v("drain_final_rd", SEL_RD0, 'h0033);
        expect_v("drain_final_busy", SEL_BUSY, 0);
        expect_v("drain_err", SEL_ERR, 0);
        expect_v("drain_ready", SEL_READY, 1);

        // Underflow on r6 sets the sticky error
        cyc(1, 0, 0, 1, 6, 'h6666, 0, 6);
        expect_v("uf_err_before", SEL_ERR, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 6);
        expect_v("uf_rd", SEL_RD1, 'h6666);
        expect_v("uf_err_set", SEL_ERR, 1);
        cyc(1, 1, 1, 0, 0, 0, 0, 6);
        expect_v("uf_err_sticky1", SEL_ERR, 1);
        cyc(1, 0, 0, 1, 1, 'h0101, 0, 6);
        expect_v("uf_err_sticky2", SEL_ERR, 1);

        // Build r1=2, r2=1 then reset during traffic
        cyc(1, 1, 1, 0, 0, 0, 1, 2);
        cyc(1, 1, 1, 0, 0, 0, 1, 2);
        cyc(1, 1, 2, 0, 0, 0, 1, 2);
        cyc(1, 0, 0, 0, 0, 0, 1, 2);
        expect_v("mid_busy_pre", SEL_BUSY, 3);
        expect_v("mid_err_pre", SEL_ERR, 1);
        cyc(0, 1, 1, 1, 2, 'h1234, 2, 1);
        expect_v("mid_rst_ready", SEL_READY, 1);
        cyc(1, 0, 0, 0, 0, 0, 2, 0);
        expect_v("mid_rd_r2", SEL_RD0, 0);
        expect_v("mid_rd_r0", SEL_RD1, 'h0400);
        expect_v("mid_err_clr", SEL_ERR, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 2);
        expect_v("mid_busy_clr", SEL_BUSY, 0);
        cyc(1, 0, 0, 0, 0, 0, 6, 5);
        expect_v("mid_rd_r6", SEL_RD0, 0);
        expect_v("mid_rd_r5", SEL_RD1, 0);

        // Let the monitor drain the queue, bounded
        for (int w = 0; w < 10 && sel_q.size() > 0; w++) @(posedge clk);
        if (sel_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_queue: got %0d pending expected 0", sel_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
